// File: rtl/epp_bus_ctrl.sv
// EPP (IEEE-1284 enhanced parallel port) slave controller.
// Turns host address/data strobes into a simple register bus with an
// auto-incrementing address pointer and a read timeout.
//
// Ports:
//   clk, nReset                 clock, async active-low reset
//   nWrite, nAddrStr, nDataStr  raw EPP control pins from the host (async)
//   nWait                       EPP handshake (0 = ready, 1 = cycle acknowledged)
//   pd_in / pd_out / pd_oe      parallel data in, read data out, output enable
//   reg_addr                    current register address pointer
//   reg_wdata, reg_we           write data and one-clock write strobe
//   reg_re, reg_ack, reg_rdata  one-clock read request, completion, read data
//   tmo_err, clr_err            sticky read-timeout flag and its clear
module epp_bus_ctrl #(
  parameter int unsigned AW  = 5,
  parameter int unsigned TMO = 15
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          nWrite,
  input  logic          nAddrStr,
  input  logic          nDataStr,
  output logic          nWait,
  input  logic [7:0]    pd_in,
  output logic [7:0]    pd_out,
  output logic          pd_oe,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic          reg_ack,
  input  logic [7:0]    reg_rdata,
  output logic          tmo_err,
  input  logic          clr_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, DECODE, RD_WAIT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sync1_q, sync2_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] pd_out_q, pd_out_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          nwait_q, nwait_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          tmo_q, tmo_d;
  logic          data_cyc_q, data_cyc_d;
  logic          rd_cyc_q, rd_cyc_d;
  logic          guard_q, guard_d;
  logic [1:0]    flush_q, flush_d;

  // Synchronized strobes: {nWrite, nAddrStr, nDataStr}
  logic s_wr_n, s_as_n, s_ds_n;
  assign s_wr_n = sync2_q[2];
  assign s_as_n = sync2_q[1];
  assign s_ds_n = sync2_q[0];

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pd_out_d   = pd_out_q;
    rcnt_d     = rcnt_q;
    nwait_d    = nwait_q;
    oe_d       = oe_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    tmo_d      = tmo_q & ~clr_err;
    data_cyc_d = data_cyc_q;
    rd_cyc_d   = rd_cyc_q;
    guard_d    = guard_q;
    flush_d    = (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;

    case (state_q)
      IDLE: begin
        nwait_d = 1'b0;
        oe_d    = 1'b0;
        // After reset the synchronizers read "inactive" until flushed; a strobe
        // held low through reset must be released before it counts as new.
        if (guard_q) begin
          if ((flush_q == 2'd0) && s_as_n && s_ds_n) begin
            guard_d = 1'b0;
          end
        end else if (!s_as_n || !s_ds_n) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (!s_as_n) begin
          data_cyc_d = 1'b0;
          if (!s_wr_n) begin
            addr_d   = pd_in[AW-1:0];
            rd_cyc_d = 1'b0;
          end else begin
            pd_out_d = DW'(addr_q);
            rd_cyc_d = 1'b1;
          end
          state_d = HOLD;
        end else if (!s_ds_n) begin
          data_cyc_d = 1'b1;
          if (!s_wr_n) begin
            we_d     = 1'b1;
            wdata_d  = pd_in;
            rd_cyc_d = 1'b0;
            state_d  = HOLD;
          end else begin
            re_d     = 1'b1;
            rcnt_d   = '0;
            rd_cyc_d = 1'b1;
            state_d  = RD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RD_WAIT: begin
        // Host abort wins over a simultaneous ack: nobody is left to take the data.
        if (s_ds_n) begin
          state_d = IDLE;
        end else if (reg_ack) begin
          pd_out_d = reg_rdata;
          state_d  = HOLD;
        end else if (rcnt_q == CW'(TMO - 1)) begin
          pd_out_d = 8'hFF;
          tmo_d    = 1'b1;
          state_d  = HOLD;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end

      HOLD: begin
        nwait_d = 1'b1;
        oe_d    = rd_cyc_q;
        if (s_as_n && s_ds_n) begin
          nwait_d = 1'b0;
          oe_d    = 1'b0;
          state_d = IDLE;
          if (data_cyc_q) begin
            addr_d = addr_q + AW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      addr_q     <= '0;
      wdata_q    <= '0;
      pd_out_q   <= '0;
      rcnt_q     <= '0;
      nwait_q    <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      tmo_q      <= 1'b0;
      data_cyc_q <= 1'b0;
      rd_cyc_q   <= 1'b0;
      guard_q    <= 1'b1;
      flush_q    <= 2'd2;
    end else begin
      state_q    <= state_d;
      sync1_q    <= {nWrite, nAddrStr, nDataStr};
      sync2_q    <= sync1_q;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pd_out_q   <= pd_out_d;
      rcnt_q     <= rcnt_d;
      nwait_q    <= nwait_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      re_q       <= re_d;
      tmo_q      <= tmo_d;
      data_cyc_q <= data_cyc_d;
      rd_cyc_q   <= rd_cyc_d;
      guard_q    <= guard_d;
      flush_q    <= flush_d;
    end
  end

  assign nWait     = nwait_q;
  assign pd_out    = pd_out_q;
  assign pd_oe     = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign tmo_err   = tmo_q;

endmodule

// File: doc/epp_bus_ctrl.md
EPP_BUS_CTRL -- requirements
Module: epp_bus_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register address width.
REQ-002 SHALL have parameter TMO, default 15, maximum clocks to wait for reg_ack on a read (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports nWrite, nAddrStr, nDataStr  input  1 each  raw EPP control pins, asynchronous.
REQ-006 SHALL have port nWait  output  1  EPP handshake; 0 = ready, 1 = cycle acknowledged.
REQ-007 SHALL have port pd_in  input  8  parallel-port data as driven by the host.
REQ-008 SHALL have ports pd_out  output  8 and pd_oe  output  1  read data and drive enable; top level tristates pd_out when pd_oe=0.
REQ-009 SHALL have port reg_addr  output  AW  current register address.
REQ-010 SHALL have ports reg_wdata  output  8 and reg_we  output  1  write data and one-clock write strobe.
REQ-011 SHALL have ports reg_re  output  1, reg_ack  input  1, reg_rdata  input  8  read request, completion, read data.
REQ-012 SHALL have ports tmo_err  output  1 and clr_err  input  1  sticky read-timeout flag and synchronous clear.

Function
REQ-013 SHALL pass nWrite, nAddrStr, nDataStr through two-flop synchronizers; only synchronized values steer the FSM.
REQ-014 SHALL implement states IDLE, DECODE, RD_WAIT, HOLD.
REQ-015 IDLE: nWait=0, pd_oe=0; either synchronized strobe low -> DECODE.
REQ-016 DECODE with address strobe low SHALL take priority over data strobe if both low.
REQ-017 Address write: addr <= pd_in[AW-1:0] -> HOLD; address read: pd_out <= zero-extended addr -> HOLD.
REQ-018 Data write: reg_we=1 for exactly one clock with reg_addr=addr, reg_wdata=pd_in -> HOLD.
REQ-019 Data read: reg_re=1 for exactly one clock with reg_addr=addr -> RD_WAIT.
REQ-020 RD_WAIT: on reg_ack, pd_out <= reg_rdata -> HOLD; reg_ack in the same clock as reg_re SHALL be accepted.
REQ-021 RD_WAIT: after TMO clocks without ack, pd_out <= 8'hFF, tmo_err <= 1 -> HOLD.
REQ-022 RD_WAIT: if the data strobe deasserts before ack/timeout (host abort), SHALL go to IDLE, addr unchanged, later reg_ack ignored.
REQ-023 HOLD: nWait=1; pd_oe=1 only for read cycles; stays until both synchronized strobes high.
REQ-024 On HOLD exit after a data cycle, addr <= addr+1 modulo 2^AW (max wraps to 0); address cycles do not increment.
REQ-025 reg_ack outside RD_WAIT SHALL be ignored; reg_we and reg_re never both high.
REQ-026 Latency: reg_we/reg_re asserted on the 3rd rising edge after the first edge sampling the strobe low; nWait rises one clock later on writes.
REQ-027 tmo_err stays 1 until clr_err=1 on a clock edge; a new timeout in the same clock as clr_err wins (flag stays 1).

Reset
REQ-028 nReset low SHALL immediately force state=IDLE, addr=0, nWait=0, pd_oe=0, pd_out=0, reg_we=0, reg_re=0, tmo_err=0, synchronizers=1 (strobes inactive).
REQ-029 Reset asserted mid-cycle SHALL abandon the transaction without increment; after release the FSM waits for a fresh strobe edge, even if a strobe is still held low (HOLD-equivalent until both strobes high).

Verification
REQ-030 Address write 0x09 then data write 0x5A -> reg_we one clock, reg_addr=9, reg_wdata=0x5A; addr=10 after strobe release.
REQ-031 Data read at addr 4, reg_ack 3 clocks after reg_re with rdata 0xC3 -> pd_out=0xC3, pd_oe=1 while nWait=1; addr=5 after release.
REQ-032 Data read with reg_ack never asserted, TMO=15 -> after 15 clocks pd_out=0xFF, tmo_err=1; clr_err clears it.
REQ-033 Addr 31 (AW=5), four consecutive data writes -> reg_addr sequence 31,0,1,2.
REQ-034 Both strobes low together with pd_in=0x03 -> treated as address write, addr=3, no reg_we.
REQ-035 nReset pulsed during RD_WAIT with strobe held low -> all outputs at reset values, no reg_re until strobe released and reasserted.
